// File: rtl/ahb_lite_regbank_slave.sv
// AHB-Lite register bank responder with programmable wait states and a two-cycle
// ERROR response; reads are registered, writes commit at the end of the data phase.
module ahb_lite_regbank_slave #(
  parameter int DATAWIDTH   = 32,
  parameter int ADDRWIDTH   = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [DATAWIDTH-1:0] HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  output logic [DATAWIDTH-1:0] HRDATA
);

  localparam int OW = $clog2(NUM_REGS);
  localparam int NB = DATAWIDTH / 8;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           wait_cnt_reg, wait_cnt_next;
  logic [OW-1:0]        off_reg;
  logic [NB-1:0]        mask_reg;
  logic                 write_reg;
  logic [DATAWIDTH-1:0] regs [NUM_REGS];
  logic [DATAWIDTH-1:0] rdata_reg;

  logic                 accept_window, accept;
  logic                 size_bad, misalign, range_bad, req_bad;
  logic [OW-1:0]        req_off;
  logic [NB-1:0]        req_mask;
  logic                 commit_en;
  logic [DATAWIDTH-1:0] wr_merged;
  logic                 rd_en, rd_write;
  logic [OW-1:0]        rd_off;
  logic [DATAWIDTH-1:0] rd_word;

  // New address phases are only taken in cycles where this slave is ready.
  assign accept_window = (state_reg == S_IDLE) || (state_reg == S_LAST) || (state_reg == S_ERR2);
  assign accept        = HSEL && HREADY && HTRANS[1] && accept_window;

  assign size_bad  = (HSIZE > 3'b010);
  assign misalign  = ((HSIZE == 3'b001) && HADDR[0]) || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign range_bad = |HADDR[ADDRWIDTH-1:2+OW];
  assign req_bad   = size_bad || misalign || range_bad;
  assign req_off   = HADDR[2+OW-1:2];

  always_comb begin
    req_mask = '1;
    case (HSIZE)
      3'b000:  req_mask = 4'b0001 << HADDR[1:0];
      3'b001:  req_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: req_mask = '1;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;
    case (state_reg)
      S_IDLE, S_LAST, S_ERR2: begin
        HRESP = (state_reg == S_ERR2);
        if (accept) begin
          if (req_bad) begin
            state_next = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = S_WAIT;
            wait_cnt_next = WS_LOAD;
          end else begin
            state_next = S_LAST;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt_reg == 4'd0) state_next = S_LAST;
        else wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = S_ERR2;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign commit_en = (state_reg == S_LAST) && write_reg;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign wr_merged[8*gi +: 8] = mask_reg[gi] ? HWDATA[8*gi +: 8] : regs[off_reg][8*gi +: 8];
    end
  endgenerate

  // A transfer entering LAST came either from WAIT (latched) or straight off the bus.
  assign rd_write = (state_reg == S_WAIT) ? write_reg : HWRITE;
  assign rd_off   = (state_reg == S_WAIT) ? off_reg : req_off;
  assign rd_en    = (state_next == S_LAST) && !rd_write;
  assign rd_word  = (commit_en && (off_reg == rd_off)) ? wr_merged : regs[rd_off];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      off_reg      <= '0;
      mask_reg     <= '0;
      write_reg    <= 1'b0;
      rdata_reg    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        off_reg   <= req_off;
        mask_reg  <= req_mask;
        write_reg <= HWRITE;
      end
      if (commit_en) regs[off_reg] <= wr_merged;
      if (rd_en) rdata_reg <= rd_word;
    end
  end

  assign HRDATA = rdata_reg;

endmodule

// File: tb/tb_ahb_lite_regbank_slave.sv
// Directed bench: one slave with two wait states and one with none, sharing the bus
// signals; HSEL steers each transfer to one of them.
module tb_ahb_lite_regbank_slave;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  int          sel;

  logic        hsel_a, hsel_b;
  logic        ro_a, rs_a, ro_b, rs_b;
  logic [31:0] rd_a, rd_b;
  logic        ro_m, rs_m;
  logic [31:0] rd_m;

  assign hsel_a = hsel && (sel == 0);
  assign hsel_b = hsel && (sel == 1);
  assign ro_m   = (sel == 0) ? ro_a : ro_b;
  assign rs_m   = (sel == 0) ? rs_a : rs_b;
  assign rd_m   = (sel == 0) ? rd_a : rd_b;

  ahb_lite_regbank_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .NUM_REGS(16), .WAIT_STATES(2)) dut_a (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro_a),
    .HREADYOUT(ro_a), .HRESP(rs_a), .HRDATA(rd_a));

  ahb_lite_regbank_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)) dut_b (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro_b),
    .HREADYOUT(ro_b), .HRESP(rs_b), .HRDATA(rd_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single transfer; called and returns at 1 time unit after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, output logic [31:0] rdata, output int nlow,
                      output logic resp_first, output logic resp_last);
    sel = d; hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    nlow = 0; resp_first = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) resp_first = rs_m;
      if (ro_m) break;
      nlow++;
    end
    check("ready_within_bound", {31'd0, ro_m}, 32'd1);
    rdata = rd_m; resp_last = rs_m;
    $display("xfer dut=%0d wr=%0d addr=%h size=%0d wdata=%h -> rdata=%h stalls=%0d resp=%0d/%0d",
             d, wr, addr, size, wd, rdata, nlow, resp_first, resp_last);
    @(posedge clk); #1;
  endtask

  // Zero-wait write immediately followed by a read on the next address phase (slave B).
  task automatic pipe(input logic [31:0] waddr, input logic [2:0] wsize, input logic [31:0] wd,
                      input logic [31:0] raddr, input logic [31:0] exp, input string tag);
    sel = 1; hsel = 1'b1; htrans = 2'b10; haddr = waddr; hwrite = 1'b1; hsize = wsize;
    @(posedge clk); #1;
    hwdata = wd; haddr = raddr; hwrite = 1'b0; hsize = 3'b010;
    @(negedge clk);
    check({tag, "_wr_ready"}, {31'd0, ro_m}, 32'd1);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check({tag, "_rd_ready"}, {31'd0, ro_m}, 32'd1);
    check({tag, "_rd_data"}, rd_m, exp);
    $display("pipe write %h=%h then read %h -> %h", waddr, wd, raddr, rd_m);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  int          nl;
  logic        rf, rl;

  initial begin
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
    hsize = 3'b010; hwdata = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_a", {31'd0, ro_a}, 32'd1);
    check("rst_resp_a",  {31'd0, rs_a}, 32'd0);
    check("rst_rdata_a", rd_a, 32'd0);
    check("rst_ready_b", {31'd0, ro_b}, 32'd1);
    check("rst_rdata_b", rd_b, 32'd0);
    hreset = 1'b0;

    xfer(0, 0, 32'h0C, 3'b010, 32'h0, rd, nl, rf, rl);
    check("rst_read3_data", rd, 32'd0);
    check("rst_read3_stalls", nl, 32'd2);

    // Wait-state write/read
    xfer(0, 1, 32'h08, 3'b010, 32'hDEADBEEF, rd, nl, rf, rl);
    check("ws_write_stalls", nl, 32'd2);
    check("ws_write_resp", {31'd0, rl}, 32'd0);
    xfer(0, 0, 32'h08, 3'b010, 32'h0, rd, nl, rf, rl);
    check("ws_read_data", rd, 32'hDEADBEEF);

    // Byte and halfword lanes
    xfer(0, 1, 32'h08, 3'b010, 32'h11223344, rd, nl, rf, rl);
    xfer(0, 1, 32'h09, 3'b000, 32'hA5A5A5A5, rd, nl, rf, rl);
    xfer(0, 0, 32'h08, 3'b010, 32'h0, rd, nl, rf, rl);
    check("byte_lane1", rd, 32'h1122A544);
    xfer(0, 1, 32'h0A, 3'b001, 32'h77887788, rd, nl, rf, rl);
    xfer(0, 0, 32'h08, 3'b010, 32'h0, rd, nl, rf, rl);
    check("half_upper", rd, 32'h7788A544);

    // Error responses; HRDATA must keep the last read value
    xfer(0, 0, 32'h40, 3'b010, 32'h0, rd, nl, rf, rl);
    check("err_range_stalls", nl, 32'd1);
    check("err_range_resp1", {31'd0, rf}, 32'd1);
    check("err_range_resp2", {31'd0, rl}, 32'd1);
    check("err_range_hrdata_held", rd, 32'h7788A544);
    xfer(0, 1, 32'h0A, 3'b010, 32'hFFFFFFFF, rd, nl, rf, rl);
    check("err_misalign_word_resp1", {31'd0, rf}, 32'd1);
    check("err_misalign_word_resp2", {31'd0, rl}, 32'd1);
    xfer(0, 1, 32'h08, 3'b011, 32'h00000000, rd, nl, rf, rl);
    check("err_size_stalls", nl, 32'd1);
    check("err_size_resp2", {31'd0, rl}, 32'd1);
    xfer(0, 1, 32'h09, 3'b001, 32'h00000000, rd, nl, rf, rl);
    check("err_misalign_half_resp2", {31'd0, rl}, 32'd1);
    xfer(0, 0, 32'h08, 3'b010, 32'h0, rd, nl, rf, rl);
    check("err_regs_unchanged", rd, 32'h7788A544);
    check("okay_after_err_resp", {31'd0, rl}, 32'd0);
    xfer(0, 0, 32'h3C, 3'b010, 32'h0, rd, nl, rf, rl);
    check("top_offset_data", rd, 32'd0);
    check("top_offset_stalls", nl, 32'd2);

    // Zero-wait pipelined transfers with forwarding
    pipe(32'h04, 3'b010, 32'hCAFEF00D, 32'h04, 32'hCAFEF00D, "fwd_word");
    xfer(1, 0, 32'h04, 3'b010, 32'h0, rd, nl, rf, rl);
    check("zw_read_data", rd, 32'hCAFEF00D);
    check("zw_read_stalls", nl, 32'd0);
    pipe(32'h05, 3'b000, 32'h5A5A5A5A, 32'h04, 32'hCAFE5A0D, "fwd_byte");
    xfer(1, 0, 32'h40, 3'b010, 32'h0, rd, nl, rf, rl);
    check("zw_err_stalls", nl, 32'd1);
    check("zw_err_resp2", {31'd0, rl}, 32'd1);

    // Reset during the wait phase of a write to offset 3
    sel = 0; hsel = 1'b1; htrans = 2'b10; haddr = 32'h0C; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h12345678;
    @(negedge clk);
    check("rstmid_stalled", {31'd0, ro_a}, 32'd0);
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {31'd0, ro_a}, 32'd1);
    check("rstmid_resp", {31'd0, rs_a}, 32'd0);
    check("rstmid_hrdata", rd_a, 32'd0);
    @(posedge clk); #1;
    xfer(0, 0, 32'h0C, 3'b010, 32'h0, rd, nl, rf, rl);
    check("rstmid_reg3", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
